// File: rtl/quad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : quad_pkg
//  Description : Shared types and helpers for the quad (1-of-4 NCL) receiver.
//                Holds the ingress and egress state encodings, the rail-index
//                width, and the one-hot check, multi-hot check and index
//                encoder used on synchronized quad samples.
//  Revision    : 1.0  initial release
// ============================================================================
package quad_pkg;

  localparam int RAIL_W = 2;

  typedef enum logic [0:0] {
    I_DATA = 1'b0,
    I_NULL = 1'b1
  } ing_state_t;

  typedef enum logic [1:0] {
    E_IDLE = 2'd0,
    E_REQ  = 2'd1,
    E_REL  = 2'd2
  } egr_state_t;

  // Exactly one rail high: a valid DATA wavefront.
  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // More than one rail high: illegal on a 1-of-4 code.
  function automatic logic is_multihot(input logic [3:0] v);
    return (v & (v - 4'd1)) != 4'd0;
  endfunction

  // Rail index of a one-hot value.
  function automatic logic [RAIL_W-1:0] encode_rail(input logic [3:0] v);
    logic [RAIL_W-1:0] idx;
    idx = '0;
    case (v)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/quadtofree_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : quadtofree_fifo
//  Description : DEPTH x RAIL_W synchronous FIFO holding decoded rail indices.
//                Push and pop on the same edge are both honoured. The
//                occupancy is registered, so an entry written at one edge is
//                visible to the popper no earlier than the next edge.
//  Ports       : clk, rst (sync, active-high)
//                push, push_data   - write request and rail index
//                pop, pop_data     - read request and head entry
//                full, empty, level- status (level is registered)
//  Revision    : 1.0  initial release
// ============================================================================
module quadtofree_fifo
  import quad_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [RAIL_W-1:0]        push_data,
  input  logic                     pop,
  output logic [RAIL_W-1:0]        pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [RAIL_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign full      = (r_count == FULL_LVL);
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign pop_data  = r_mem[r_rptr];
  assign level     = r_count;

  // Storage needs no reset: contents are only read while count says valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= push_data;
  end

  // DEPTH is a power of two, so natural pointer overflow is the wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/quadtofree.sv
`default_nettype none
// ============================================================================
//  Module      : quadtofree
//  Description : Clocked receiver for a 1-of-4 NCL quad stream. Accepts
//                DATA/NULL wavefronts on quad, acknowledges via quadCOMP,
//                buffers rail indices in a FIFO and replays each one as a
//                four-phase request on channel R0..R3.
//  Ports       : clk, init (sync, active-high reset)
//                quad[3:0]   - NCL datum in (async), all-zero = NULL
//                quadCOMP    - completion out: 0 asks DATA, 1 asks NULL
//                R0..R3      - per-channel request out
//                R0COMP..R3COMP - per-channel completion in (async)
//                err         - sticky multi-rail error
//                level       - FIFO occupancy
//  Revision    : 1.0  initial release
// ============================================================================
module quadtofree
  import quad_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SYNC  = 2
) (
  input  logic                   clk,
  input  logic                   init,
  input  logic [3:0]             quad,
  output logic                   quadCOMP,
  output logic                   R0,
  output logic                   R1,
  output logic                   R2,
  output logic                   R3,
  input  logic                   R0COMP,
  input  logic                   R1COMP,
  input  logic                   R2COMP,
  input  logic                   R3COMP,
  output logic                   err,
  output logic [$clog2(DEPTH):0] level
);

  // ---------------- synchronizers ----------------
  logic [SYNC-1:0][3:0] r_quad_sync;
  logic [SYNC-1:0][3:0] r_comp_sync;
  logic [3:0]           r_quad_prev;
  logic [3:0]           w_quad_s;
  logic [3:0]           w_comp_s;
  logic                 w_stable;
  logic                 w_multi;

  always_ff @(posedge clk) begin
    if (init) begin
      r_quad_sync <= '0;
      r_comp_sync <= '0;
      r_quad_prev <= '0;
    end else begin
      r_quad_sync <= {r_quad_sync[SYNC-2:0], quad};
      r_comp_sync <= {r_comp_sync[SYNC-2:0], {R3COMP, R2COMP, R1COMP, R0COMP}};
      r_quad_prev <= w_quad_s;
    end
  end

  assign w_quad_s = r_quad_sync[SYNC-1];
  assign w_comp_s = r_comp_sync[SYNC-1];
  // Two equal consecutive synchronized samples filter rail skew.
  assign w_stable = (w_quad_s == r_quad_prev);
  assign w_multi  = is_multihot(w_quad_s);

  // ---------------- FIFO ----------------
  logic              w_push;
  logic              w_pop;
  logic [RAIL_W-1:0] w_head;
  logic              w_full;
  logic              w_empty;

  quadtofree_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (init),
    .push      (w_push),
    .push_data (encode_rail(w_quad_s)),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .level     (level)
  );

  // ---------------- ingress FSM ----------------
  ing_state_t r_istate;
  ing_state_t w_inext;
  logic       r_quad_comp;
  logic       r_err;

  always_ff @(posedge clk) begin
    if (init) begin
      r_istate    <= I_DATA;
      r_quad_comp <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_istate    <= w_inext;
      r_quad_comp <= (w_inext == I_NULL);
      r_err       <= r_err | w_multi;
    end
  end

  // A one-hot sample seen in I_NULL is the same DATA wavefront still held,
  // so only I_DATA may push.
  always_comb begin
    w_inext = r_istate;
    w_push  = 1'b0;
    if (!w_multi && w_stable) begin
      case (r_istate)
        I_DATA: begin
          if (is_onehot(w_quad_s) && !w_full) begin
            w_push  = 1'b1;
            w_inext = I_NULL;
          end
        end
        I_NULL: begin
          if (w_quad_s == 4'd0) w_inext = I_DATA;
        end
        default: w_inext = I_DATA;
      endcase
    end
  end

  assign quadCOMP = r_quad_comp;
  assign err      = r_err;

  // ---------------- egress FSM ----------------
  egr_state_t        r_estate;
  egr_state_t        w_enext;
  logic [RAIL_W-1:0] r_sel;
  logic [RAIL_W-1:0] w_sel_next;
  logic [3:0]        r_req;
  logic [3:0]        w_req_next;

  always_ff @(posedge clk) begin
    if (init) begin
      r_estate <= E_IDLE;
      r_sel    <= '0;
      r_req    <= '0;
    end else begin
      r_estate <= w_enext;
      r_sel    <= w_sel_next;
      r_req    <= w_req_next;
    end
  end

  // Only the selected channel's completion is observed.
  always_comb begin
    w_enext    = r_estate;
    w_pop      = 1'b0;
    w_sel_next = r_sel;
    w_req_next = r_req;
    case (r_estate)
      E_IDLE: begin
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_sel_next = w_head;
          w_req_next = 4'b0001 << w_head;
          w_enext    = E_REQ;
        end
      end
      E_REQ: begin
        if (w_comp_s[r_sel]) begin
          w_req_next = '0;
          w_enext    = E_REL;
        end
      end
      E_REL: begin
        if (!w_comp_s[r_sel]) w_enext = E_IDLE;
      end
      default: begin
        w_req_next = '0;
        w_enext    = E_IDLE;
      end
    endcase
  end

  assign R0 = r_req[0];
  assign R1 = r_req[1];
  assign R2 = r_req[2];
  assign R3 = r_req[3];

endmodule
`default_nettype wire

// File: tb/tb_quadtofree.sv
`default_nettype none
// ============================================================================
//  Module      : tb_quadtofree
//  Description : Self-checking bench for quadtofree. A driver sends tokens as
//                DATA/NULL wavefronts and queues the rail it sent; a monitor
//                pops that queue on every request rise; a responder answers
//                requests with completions after a random delay.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_quadtofree;

  localparam int DEPTH = 4;
  localparam int SYNC  = 2;

  logic       clk = 1'b0;
  logic       init;
  logic [3:0] quad;
  logic       quadCOMP;
  logic       R0, R1, R2, R3;
  logic [3:0] comp;
  logic       err;
  logic [$clog2(DEPTH):0] level;
  logic [3:0] rv;

  assign rv = {R3, R2, R1, R0};

  always #5 clk = ~clk;

  quadtofree #(
    .DEPTH(DEPTH),
    .SYNC (SYNC)
  ) dut (
    .clk     (clk),
    .init    (init),
    .quad    (quad),
    .quadCOMP(quadCOMP),
    .R0      (R0),
    .R1      (R1),
    .R2      (R2),
    .R3      (R3),
    .R0COMP  (comp[0]),
    .R1COMP  (comp[1]),
    .R2COMP  (comp[2]),
    .R3COMP  (comp[3]),
    .err     (err),
    .level   (level)
  );

  int   passed = 0;
  int   total  = 0;
  int   exp_q[$];        // rails sent and not yet seen as a request
  bit   hold_comp = 1'b0; // responder stays silent while set

  task automatic check(input bit ok, input string name, input int act, input int req);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  function automatic int first_one(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // ---------------- monitor ----------------
  logic [3:0] prev_rv = 4'd0;
  always @(negedge clk) begin
    int got;
    check($countones(rv) <= 1, "req_onehot", int'(rv), 0);
    if ((rv & ~prev_rv) != 4'd0) begin
      got = first_one(rv & ~prev_rv);
      if (exp_q.size() == 0) check(1'b0, "unexpected_req", got, -1);
      else begin
        int e;
        e = exp_q.pop_front();
        check(got == e, "req_order", got, e);
      end
    end
    prev_rv = rv;
  end

  // ---------------- responder ----------------
  initial begin
    int k, t;
    forever begin
      @(posedge clk); #1;
      if (!hold_comp && rv != 4'd0 && comp == 4'd0) begin
        k = first_one(rv);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1 comp[k] = 1'b1;
        t = 0;
        do begin @(posedge clk); #1; t++; end while (rv[k] && t < 50);
        check(t == SYNC + 1, "comp_to_release", t, SYNC + 1);
        comp[k] = 1'b0;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_ack(input logic v, input int limit, input string name);
    int t;
    t = 0;
    while (quadCOMP !== v && t < limit) begin @(posedge clk); #1; t++; end
    check(quadCOMP === v, name, int'(quadCOMP), int'(v));
  endtask

  task automatic send_token(input int k);
    @(posedge clk); #1;
    quad = 4'b0001 << k;
    exp_q.push_back(k);
    wait_ack(1'b1, 2000, "ack_rise");
    @(posedge clk); #1;
    quad = 4'd0;
    wait_ack(1'b0, 100, "ack_fall");
  endtask

  task automatic quiesce();
    int t;
    t = 0;
    while ((level != 0 || rv != 0 || comp != 0) && t < 3000) begin
      @(posedge clk); #1; t++;
    end
    check(t < 3000, "quiesce", t, 0);
    repeat (6) @(posedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int t, k, d;
    bit seen;
    init = 1'b1;
    quad = 4'd0;
    comp = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check(quadCOMP == 1'b0, "rst_quadCOMP", int'(quadCOMP), 0);
    check(rv == 4'd0,       "rst_R",        int'(rv), 0);
    check(err == 1'b0,      "rst_err",      int'(err), 0);
    check(level == 0,       "rst_level",    int'(level), 0);
    init = 1'b0;
    repeat (2) @(posedge clk);

    // Single DATA 0010 then NULL, with acknowledge latency.
    @(posedge clk); #1;
    quad = 4'b0010;
    exp_q.push_back(1);
    t = 0;
    do begin @(posedge clk); #1; t++; end while (!quadCOMP && t < 50);
    check(t == SYNC + 2, "ack_rise_latency", t, SYNC + 2);
    @(posedge clk); #1;
    quad = 4'd0;
    t = 0;
    do begin @(posedge clk); #1; t++; end while (quadCOMP && t < 50);
    check(t == SYNC + 2, "ack_fall_latency", t, SYNC + 2);
    quiesce();

    // Ordered tokens, then random traffic.
    send_token(3);
    send_token(0);
    send_token(2);
    send_token(1);
    for (int i = 0; i < 40; i++) begin
      send_token(int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    quiesce();

    // Fill the FIFO with completions withheld.
    hold_comp = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_token(int'($urandom_range(0, 3)));
      if (i == 3) check(level == 3, "level_three", int'(level), 3);
      if (i == 4) check(level == 4, "level_full", int'(level), 4);
    end
    k = int'($urandom_range(0, 3));
    @(posedge clk); #1;
    quad = 4'b0001 << k;
    exp_q.push_back(k);
    seen = 1'b0;
    repeat (15) begin @(posedge clk); #1; if (quadCOMP) seen = 1'b1; end
    check(!seen, "full_stall", int'(seen), 0);
    hold_comp = 1'b0;
    wait_ack(1'b1, 200, "ack_after_pop");
    @(posedge clk); #1;
    quad = 4'd0;
    wait_ack(1'b0, 100, "ack_fall_after_pop");
    quiesce();

    // Multi-rail error.
    @(posedge clk); #1;
    quad = 4'b0101;
    seen = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (quadCOMP) seen = 1'b1; end
    check(err == 1'b1, "err_set",        int'(err), 1);
    check(!seen,       "err_no_ack",     int'(seen), 0);
    check(level == 0,  "err_no_push",    int'(level), 0);
    check(rv == 4'd0,  "err_no_request", int'(rv), 0);
    quad = 4'd0;
    repeat (6) @(posedge clk);
    send_token(int'($urandom_range(0, 3)));
    quiesce();
    check(err == 1'b1, "err_sticky", int'(err), 1);

    // Reset during E_REQ with two entries queued.
    hold_comp = 1'b1;
    for (int i = 0; i < 3; i++) send_token(int'($urandom_range(0, 3)));
    repeat (2) @(posedge clk);
    #1;
    check(level == 2,          "pre_init_level", int'(level), 2);
    check($countones(rv) == 1, "pre_init_req",   int'(rv), 1);
    @(posedge clk); #1;
    init = 1'b1;
    @(posedge clk); #1;
    check(rv == 4'd0,      "init_R",        int'(rv), 0);
    check(level == 0,      "init_level",    int'(level), 0);
    check(quadCOMP == 1'b0,"init_quadCOMP", int'(quadCOMP), 0);
    check(err == 1'b0,     "init_err",      int'(err), 0);
    exp_q.delete();
    init = 1'b0;
    repeat (4) @(posedge clk);

    // Push and pop on the same edge at level 2.
    for (int i = 0; i < 3; i++) send_token(int'($urandom_range(0, 3)));
    repeat (2) @(posedge clk);
    #1;
    k = first_one(rv);
    if (k < 0) k = 0;
    comp[k] = 1'b1;
    t = 0;
    do begin @(posedge clk); #1; t++; end while (rv[k] && t < 50);
    check(t == SYNC + 1, "manual_release", t, SYNC + 1);
    // Completion fall and the new DATA wavefront both need SYNC+2 edges,
    // so the pop and the push land on the same edge.
    d = int'($urandom_range(0, 3));
    comp[k] = 1'b0;
    quad = 4'b0001 << d;
    exp_q.push_back(d);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check(level == 2, "level_push_pop", int'(level), 2);
    end
    check(quadCOMP == 1'b1, "push_pop_ack", int'(quadCOMP), 1);
    quad = 4'd0;
    wait_ack(1'b0, 100, "push_pop_ack_fall");
    hold_comp = 1'b0;
    quiesce();

    check(exp_q.size() == 0, "all_tokens_replayed", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
